// File: rtl/cpu_exec_units_if.sv
// Signal bundle between the core's control/datapath and the execution helper units.
// The master side is the core; the slave side is cpu_exec_units.
interface cpu_exec_units_if;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_borrow;
    logic        alu_lt;

    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wenable;

    logic [31:0] ext_data;
    logic [2:0]  ext_control;
    logic [31:0] ext_data_out;

    modport master (
        output alu_src_a, alu_src_b, alu_control,
        input  alu_result, alu_zero, alu_borrow, alu_lt,
        output csr_raddr, csr_waddr, csr_wdata, csr_wenable,
        input  csr_rdata,
        output ext_data, ext_control,
        input  ext_data_out
    );

    modport slave (
        input  alu_src_a, alu_src_b, alu_control,
        output alu_result, alu_zero, alu_borrow, alu_lt,
        input  csr_raddr, csr_waddr, csr_wdata, csr_wenable,
        output csr_rdata,
        input  ext_data, ext_control,
        output ext_data_out
    );
endinterface

// File: rtl/cpu_exec_units.sv
// RV32 execution helpers: combinational ALU with compare flags, machine-mode CSR file
// with a 64-bit cycle counter, and a combinational load-data extender.
module cpu_exec_units #(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0120
) (
    input logic             clk,
    input logic             rst_n,
    cpu_exec_units_if.slave bus
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMisa     = 12'h301;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMtval    = 12'h343;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMcycleh  = 12'hB80;
    localparam logic [11:0] AddrCycle    = 12'hC00;
    localparam logic [11:0] AddrCycleh   = 12'hC80;
    localparam logic [11:0] AddrMhartid  = 12'hF14;

    // ---------------- ALU ----------------
    logic [4:0]  shamt;
    logic [31:0] alu_res;

    assign shamt = bus.alu_src_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        unique case (bus.alu_control)
            4'b0000: alu_res = bus.alu_src_a + bus.alu_src_b;
            4'b1000: alu_res = bus.alu_src_a - bus.alu_src_b;
            4'b0001: alu_res = bus.alu_src_a << shamt;
            4'b0010: alu_res = {31'd0, bus.alu_lt};
            4'b0011: alu_res = {31'd0, bus.alu_borrow};
            4'b0100: alu_res = bus.alu_src_a ^ bus.alu_src_b;
            4'b0101: alu_res = bus.alu_src_a >> shamt;
            4'b1101: alu_res = $unsigned($signed(bus.alu_src_a) >>> shamt);
            4'b0110: alu_res = bus.alu_src_a | bus.alu_src_b;
            4'b0111: alu_res = bus.alu_src_a & bus.alu_src_b;
            4'b1001: alu_res = bus.alu_src_a;
            4'b1010: alu_res = bus.alu_src_b;
            4'b1011: alu_res = bus.alu_src_a & ~bus.alu_src_b;
            default: alu_res = 32'd0;
        endcase
    end

    assign bus.alu_result = alu_res;
    assign bus.alu_zero   = (alu_res == 32'd0);
    assign bus.alu_borrow = (bus.alu_src_a < bus.alu_src_b);
    assign bus.alu_lt     = ($signed(bus.alu_src_a) < $signed(bus.alu_src_b));

    // ---------------- Load extender ----------------
    always_comb begin
        bus.ext_data_out = bus.ext_data;
        case (bus.ext_control)
            3'b000:  bus.ext_data_out = {{24{bus.ext_data[7]}}, bus.ext_data[7:0]};
            3'b001:  bus.ext_data_out = {{16{bus.ext_data[15]}}, bus.ext_data[15:0]};
            3'b100:  bus.ext_data_out = {24'd0, bus.ext_data[7:0]};
            3'b101:  bus.ext_data_out = {16'd0, bus.ext_data[15:0]};
            default: bus.ext_data_out = bus.ext_data;
        endcase
    end

    // ---------------- CSR file ----------------
    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
    logic [31:0] mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d, mip_d;
    logic [63:0] cycle_q, cycle_d;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = mip_q;
        cycle_d    = cycle_q + 64'd1;

        if (bus.csr_wenable) begin
            case (bus.csr_waddr)
                AddrMstatus:  mstatus_d  = bus.csr_wdata;
                AddrMie:      mie_d      = bus.csr_wdata;
                AddrMtvec:    mtvec_d    = bus.csr_wdata;
                AddrMscratch: mscratch_d = bus.csr_wdata;
                AddrMepc:     mepc_d     = bus.csr_wdata;
                AddrMcause:   mcause_d   = bus.csr_wdata;
                AddrMtval:    mtval_d    = bus.csr_wdata;
                AddrMip:      mip_d      = bus.csr_wdata;
                // A software write to either half suppresses this cycle's increment.
                AddrMcycle:   cycle_d    = {cycle_q[63:32], bus.csr_wdata};
                AddrMcycleh:  cycle_d    = {bus.csr_wdata, cycle_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= 32'd0;
            mie_q      <= 32'd0;
            mtvec_q    <= 32'd0;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mip_q      <= 32'd0;
            cycle_q    <= 64'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            cycle_q    <= cycle_d;
        end
    end

    // Reads see register state only, so a same-cycle write returns the old value.
    always_comb begin
        bus.csr_rdata = 32'd0;
        case (bus.csr_raddr)
            AddrMstatus:              bus.csr_rdata = mstatus_q;
            AddrMisa:                 bus.csr_rdata = MISA_VALUE;
            AddrMie:                  bus.csr_rdata = mie_q;
            AddrMtvec:                bus.csr_rdata = mtvec_q;
            AddrMscratch:             bus.csr_rdata = mscratch_q;
            AddrMepc:                 bus.csr_rdata = mepc_q;
            AddrMcause:               bus.csr_rdata = mcause_q;
            AddrMtval:                bus.csr_rdata = mtval_q;
            AddrMip:                  bus.csr_rdata = mip_q;
            AddrMcycle, AddrCycle:    bus.csr_rdata = cycle_q[31:0];
            AddrMcycleh, AddrCycleh:  bus.csr_rdata = cycle_q[63:32];
            AddrMhartid:              bus.csr_rdata = HART_ID;
            default:                  bus.csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cpu_exec_units.sv
// Self-checking bench for cpu_exec_units: directed cases plus randomized traffic
// compared against a behavioural model of the ALU, extender and CSR file.
module tb_cpu_exec_units;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cpu_exec_units_if bus ();

    cpu_exec_units #(
        .HART_ID    (32'd0),
        .MISA_VALUE (32'h4000_0120)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Reference model ----------------
    logic [31:0] m_csr [0:4095];
    logic [63:0] m_cnt;

    function automatic bit m_is_rw(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344};
    endfunction

    function automatic logic [31:0] m_csr_read(input logic [11:0] a);
        if (m_is_rw(a)) return m_csr[a];
        if (a == 12'hB00 || a == 12'hC00) return m_cnt[31:0];
        if (a == 12'hB80 || a == 12'hC80) return m_cnt[63:32];
        if (a == 12'h301) return 32'h4000_0120;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        longint sa;
        sh = b % 32;
        sa = longint'($signed(a));
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return 32'(64'(a) * (64'd1 << sh));
            4'b0010: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'b0011: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a / (32'd1 << sh);
            4'b1101: return 32'(sa >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1001: return a;
            4'b1010: return b;
            4'b1011: return a & ~b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f, input logic [31:0] d);
        int signed v;
        case (f)
            3'b000: begin v = int'($signed(d[7:0]));  return 32'(v); end
            3'b001: begin v = int'($signed(d[15:0])); return 32'(v); end
            3'b100: return d & 32'h0000_00FF;
            3'b101: return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    // Advance the model with the inputs currently applied, then cross one clock edge.
    task automatic step();
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) m_csr[i] = 32'd0;
            m_cnt = 64'd0;
        end else if (bus.csr_wenable && bus.csr_waddr == 12'hB00) begin
            m_cnt[31:0] = bus.csr_wdata;
        end else if (bus.csr_wenable && bus.csr_waddr == 12'hB80) begin
            m_cnt[63:32] = bus.csr_wdata;
        end else begin
            if (bus.csr_wenable && m_is_rw(bus.csr_waddr)) m_csr[bus.csr_waddr] = bus.csr_wdata;
            m_cnt = m_cnt + 64'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic alu_case(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control = op;
        bus.alu_src_a   = a;
        bus.alu_src_b   = b;
        #1;
    endtask

    logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hC00,
                                12'hC80, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0,
                                12'h000, 12'hFFF};
    logic [3:0] ops [14] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7,
                             4'h9, 4'hA, 4'hB, 4'hF};

    initial begin
        logic [31:0] a, b, r;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) m_csr[i] = 32'd0;
        m_cnt = 64'd0;
        rst_n           = 1'b0;
        bus.alu_src_a   = '0;
        bus.alu_src_b   = '0;
        bus.alu_control = '0;
        bus.csr_raddr   = 12'hB00;
        bus.csr_waddr   = '0;
        bus.csr_wdata   = '0;
        bus.csr_wenable = 1'b0;
        bus.ext_data    = '0;
        bus.ext_control = '0;
        step();
        step();

        // Counter out of reset: 0, 1, 2, 3
        rst_n = 1'b1;
        #1;
        check("mcycle_rst", bus.csr_rdata, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("mcycle_count", bus.csr_rdata, 32'(i));
        end

        // Counter carry into mcycleh
        bus.csr_wenable = 1'b1;
        bus.csr_waddr   = 12'hB00;
        bus.csr_wdata   = 32'hFFFF_FFFF;
        step();
        bus.csr_wenable = 1'b0;
        #1;
        check("mcycle_written", bus.csr_rdata, 32'hFFFF_FFFF);
        step();
        check("mcycle_wrap", bus.csr_rdata, 32'd0);
        bus.csr_raddr = 12'hB80;
        #1;
        check("mcycleh_carry", bus.csr_rdata, 32'd1);
        bus.csr_raddr = 12'hC80;
        #1;
        check("cycleh_alias", bus.csr_rdata, 32'd1);

        // ALU directed
        alu_case(4'b1000, 32'd5, 32'd7);
        check("sub_res", bus.alu_result, 32'hFFFF_FFFE);
        check("sub_zero", 32'(bus.alu_zero), 32'd0);
        check("sub_borrow", 32'(bus.alu_borrow), 32'd1);
        check("sub_lt", 32'(bus.alu_lt), 32'd1);
        alu_case(4'b0000, 32'h8000_0000, 32'd1);
        check("min_borrow", 32'(bus.alu_borrow), 32'd0);
        check("min_lt", 32'(bus.alu_lt), 32'd1);
        alu_case(4'b1000, 32'd9, 32'd9);
        check("eq_zero", 32'(bus.alu_zero), 32'd1);
        alu_case(4'b0001, 32'h8000_0010, 32'h24);
        check("sll", bus.alu_result, 32'h0000_0100);
        alu_case(4'b0101, 32'h8000_0010, 32'h24);
        check("srl", bus.alu_result, 32'h0800_0001);
        alu_case(4'b1101, 32'h8000_0010, 32'h24);
        check("sra", bus.alu_result, 32'hF800_0001);
        alu_case(4'b1011, 32'hF0F0, 32'h0FF0);
        check("and_not", bus.alu_result, 32'hF000);
        alu_case(4'b1001, 32'hF0F0, 32'h0FF0);
        check("pass_a", bus.alu_result, 32'hF0F0);
        alu_case(4'b1010, 32'hF0F0, 32'h0FF0);
        check("pass_b", bus.alu_result, 32'h0FF0);
        alu_case(4'b1111, 32'hF0F0, 32'h0FF0);
        check("op_1111", bus.alu_result, 32'd0);
        check("op_1111_zero", 32'(bus.alu_zero), 32'd1);

        // Extender directed
        bus.ext_data = 32'h1234_80F5;
        bus.ext_control = 3'b000; #1; check("lb",  bus.ext_data_out, 32'hFFFF_FFF5);
        bus.ext_control = 3'b100; #1; check("lbu", bus.ext_data_out, 32'h0000_00F5);
        bus.ext_control = 3'b001; #1; check("lh",  bus.ext_data_out, 32'hFFFF_80F5);
        bus.ext_control = 3'b101; #1; check("lhu", bus.ext_data_out, 32'h0000_80F5);
        bus.ext_control = 3'b010; #1; check("lw",  bus.ext_data_out, 32'h1234_80F5);
        bus.ext_control = 3'b111; #1; check("ext_111", bus.ext_data_out, 32'h1234_80F5);

        // CSR same-cycle read/write
        bus.csr_raddr   = 12'h340;
        bus.csr_waddr   = 12'h340;
        bus.csr_wdata   = 32'hDEAD_BEEF;
        bus.csr_wenable = 1'b1;
        #1;
        check("mscratch_old", bus.csr_rdata, 32'd0);
        step();
        bus.csr_wenable = 1'b0;
        #1;
        check("mscratch_new", bus.csr_rdata, 32'hDEAD_BEEF);

        bus.csr_waddr   = 12'h301;
        bus.csr_wdata   = 32'h1234_5678;
        bus.csr_wenable = 1'b1;
        step();
        bus.csr_wenable = 1'b0;
        bus.csr_raddr   = 12'h301;
        #1;
        check("misa_ro", bus.csr_rdata, 32'h4000_0120);
        bus.csr_raddr = 12'h7C0;
        #1;
        check("unimpl", bus.csr_rdata, 32'd0);

        // Reset overrides a same-cycle write
        rst_n           = 1'b0;
        bus.csr_waddr   = 12'h340;
        bus.csr_wdata   = 32'h5555_AAAA;
        bus.csr_wenable = 1'b1;
        step();
        bus.csr_wenable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.csr_raddr = addrs[i];
            #1;
            check("rst_csr", bus.csr_rdata, (addrs[i] == 12'h301) ? 32'h4000_0120 : 32'd0);
        end
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) b = b & 32'h3F;
            bus.alu_control = ($urandom_range(0, 9) == 0) ? 4'($urandom) :
                              ops[$urandom_range(0, 13)];
            bus.alu_src_a   = a;
            bus.alu_src_b   = b;
            bus.ext_data    = $urandom;
            bus.ext_control = 3'($urandom);
            bus.csr_raddr   = addrs[$urandom_range(0, 19)];
            bus.csr_waddr   = addrs[$urandom_range(0, 19)];
            bus.csr_wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                         : $urandom;
            bus.csr_wenable = ($urandom_range(0, 2) == 0);
            rst_n           = ($urandom_range(0, 39) != 0);
            #1;
            r = m_alu(bus.alu_control, a, b);
            check("rnd_alu", bus.alu_result, r);
            check("rnd_zero", 32'(bus.alu_zero), (r == 32'd0) ? 32'd1 : 32'd0);
            check("rnd_borrow", 32'(bus.alu_borrow), m_alu(4'b0011, a, b));
            check("rnd_lt", 32'(bus.alu_lt), m_alu(4'b0010, a, b));
            check("rnd_ext", bus.ext_data_out, m_ext(bus.ext_control, bus.ext_data));
            check("rnd_csr", bus.csr_rdata, m_csr_read(bus.csr_raddr));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
